// File: rtl/uart_sha256_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_sha256_frame_ctrl
//
// Length-framed command controller between the UART RX/TX cores and the SHA-256
// hasher. A frame is SOF (0x01), a LEN_BYTES big-endian length N, then N
// binary-transparent payload bytes. The payload is streamed into the hasher.
// The reply is ACK (0x06) followed by the first OUT_BYTES digest bytes (most
// significant first), or NAK (0x15) on a framing error or an inter-byte timeout.
//
// Compile-time option:
//   UART_SHA_ASCII_HEX_EN - when defined, the digest is sent as 2*OUT_BYTES
//                           lowercase ASCII hex characters (high nibble first)
//                           followed by 0x0A. When undefined, the digest is
//                           sent as raw bytes with no trailer.
//
// Ports:
//   clk       in   1    clock
//   rst       in   1    asynchronous active-high reset
//   rx_data   in   8    byte from UART RX core
//   rx_valid  in   1    one-cycle strobe, rx_data valid
//   tx_data   out  8    byte to UART TX core
//   tx_start  out  1    one-cycle pulse, launch tx_data
//   tx_busy   in   1    TX core busy
//   sp_start  out  1    one-cycle pulse, begin new hash
//   sp_data   out  8    payload byte to hasher
//   sp_valid  out  1    sp_data valid, one cycle per byte
//   sp_last   out  1    with sp_valid on the final payload byte
//   sp_hash   in   256  digest, word H0 in [255:224]
//   sp_done   in   1    digest valid strobe
//   busy      out  1    high in every state except IDLE
//   err       out  1    one-cycle pulse whenever a NAK is queued
// -----------------------------------------------------------------------------
module uart_sha256_frame_ctrl #(
  parameter int LEN_BYTES   = 2,
  parameter int MAX_LEN     = 4096,
  parameter int OUT_BYTES   = 32,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [7:0]   tx_data,
  output logic         tx_start,
  input  logic         tx_busy,
  output logic         sp_start,
  output logic [7:0]   sp_data,
  output logic         sp_valid,
  output logic         sp_last,
  input  logic [255:0] sp_hash,
  input  logic         sp_done,
  output logic         busy,
  output logic         err
);

  localparam int LW  = LEN_BYTES * 8;
  localparam int LCW = $clog2(LEN_BYTES + 1);
  localparam int CW  = $clog2(MAX_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
`ifdef UART_SHA_ASCII_HEX_EN
  localparam int NUM_TX = 2 * OUT_BYTES + 1;  // hex characters plus newline
`else
  localparam int NUM_TX = OUT_BYTES;
`endif
  localparam int IW = $clog2(NUM_TX + 1);

  localparam logic [7:0] SOF_BYTE = 8'h01;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_HASH,
    S_TX_ACK,
    S_TX_DIG,
    S_TX_NAK,
    S_TX_GAP
  } state_t;

  // State and datapath registers
  state_t         r_state, w_state_next;
  state_t         r_ret, w_ret_next;          // state to resume after TX_GAP
  logic [LW-1:0]  r_len, w_len_next;
  logic [LCW-1:0] r_lcnt, w_lcnt_next;        // length bytes received
  logic [CW-1:0]  r_cnt, w_cnt_next;          // payload bytes received
  logic [TW-1:0]  r_to_cnt, w_to_cnt_next;    // idle cycles since last RX byte
  logic [255:0]   r_hash, w_hash_next;
  logic [IW-1:0]  r_idx, w_idx_next;          // digest character index

  // Registered outputs
  logic [7:0]     r_tx_data, w_tx_data_next;
  logic           r_tx_start, w_tx_start_next;
  logic           r_sp_start, w_sp_start_next;
  logic [7:0]     r_sp_data, w_sp_data_next;
  logic           r_sp_valid, w_sp_valid_next;
  logic           r_sp_last, w_sp_last_next;
  logic           r_busy, w_busy_next;
  logic           r_err, w_err_next;

  // Helper nets
  logic [LW-1:0]  w_len_shift;
  logic           w_len_bad;
  logic [CW-1:0]  w_cnt_inc;
  logic           w_in_frame;
  logic           w_timeout;
  logic [255:0]   w_hash_shift;
  logic [7:0]     w_dig_byte;
  logic           w_dig_last;

  // Length register shifts MSB first; the cast keeps the low LW bits.
  assign w_len_shift = LW'({r_len, rx_data});
  assign w_len_bad   = (w_len_shift == '0) || (64'(w_len_shift) > 64'(MAX_LEN));
  assign w_cnt_inc   = r_cnt + 1'b1;

  assign w_in_frame  = (r_state == S_LEN) || (r_state == S_DATA);
  // An RX byte in the same cycle always wins over expiry.
  assign w_timeout   = w_in_frame && !rx_valid && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

  assign w_dig_last  = (r_idx == IW'(NUM_TX - 1));

`ifdef UART_SHA_ASCII_HEX_EN
  logic [3:0] w_nib;
  assign w_hash_shift = r_hash << {r_idx, 2'b00};
  assign w_nib        = w_hash_shift[255:252];
  always_comb begin
    w_dig_byte = 8'h0A;
    if (!w_dig_last) begin
      if (w_nib < 4'd10) w_dig_byte = 8'h30 + {4'h0, w_nib};
      else               w_dig_byte = 8'h57 + {4'h0, w_nib};  // 0x61 - 10
    end
  end
`else
  assign w_hash_shift = r_hash << {r_idx, 3'b000};
  assign w_dig_byte   = w_hash_shift[255:248];
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ret      <= S_IDLE;
      r_len      <= '0;
      r_lcnt     <= '0;
      r_cnt      <= '0;
      r_to_cnt   <= '0;
      r_hash     <= '0;
      r_idx      <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_sp_start <= 1'b0;
      r_sp_data  <= '0;
      r_sp_valid <= 1'b0;
      r_sp_last  <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ret      <= w_ret_next;
      r_len      <= w_len_next;
      r_lcnt     <= w_lcnt_next;
      r_cnt      <= w_cnt_next;
      r_to_cnt   <= w_to_cnt_next;
      r_hash     <= w_hash_next;
      r_idx      <= w_idx_next;
      r_tx_data  <= w_tx_data_next;
      r_tx_start <= w_tx_start_next;
      r_sp_start <= w_sp_start_next;
      r_sp_data  <= w_sp_data_next;
      r_sp_valid <= w_sp_valid_next;
      r_sp_last  <= w_sp_last_next;
      r_busy     <= w_busy_next;
      r_err      <= w_err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_ret_next      = r_ret;
    w_len_next      = r_len;
    w_lcnt_next     = r_lcnt;
    w_cnt_next      = r_cnt;
    w_hash_next     = r_hash;
    w_idx_next      = r_idx;
    w_tx_data_next  = r_tx_data;
    w_tx_start_next = 1'b0;
    w_sp_start_next = 1'b0;
    w_sp_data_next  = r_sp_data;
    w_sp_valid_next = 1'b0;
    w_sp_last_next  = 1'b0;
    w_err_next      = 1'b0;

    // Idle counter only runs while a frame is being received.
    if (w_in_frame && !rx_valid) w_to_cnt_next = r_to_cnt + 1'b1;
    else                         w_to_cnt_next = '0;

    case (r_state)
      S_IDLE: begin
        if (rx_valid && (rx_data == SOF_BYTE)) begin
          w_state_next = S_LEN;
          w_lcnt_next  = '0;
          w_len_next   = '0;
        end
      end

      S_LEN: begin
        if (rx_valid) begin
          w_len_next  = w_len_shift;
          w_lcnt_next = r_lcnt + 1'b1;
          if (r_lcnt == LCW'(LEN_BYTES - 1)) begin
            if (w_len_bad) begin
              w_state_next = S_TX_NAK;
              w_err_next   = 1'b1;
            end else begin
              w_state_next    = S_DATA;
              w_sp_start_next = 1'b1;
              w_cnt_next      = '0;
            end
          end
        end else if (w_timeout) begin
          w_state_next = S_TX_NAK;
          w_err_next   = 1'b1;
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          w_sp_data_next  = rx_data;
          w_sp_valid_next = 1'b1;
          w_cnt_next      = w_cnt_inc;
          if (64'(w_cnt_inc) == 64'(r_len)) begin
            w_sp_last_next = 1'b1;
            w_state_next   = S_HASH;
          end
        end else if (w_timeout) begin
          // The partially fed hash is abandoned; the next sp_start restarts it.
          w_state_next = S_TX_NAK;
          w_err_next   = 1'b1;
        end
      end

      S_HASH: begin
        if (sp_done) begin
          w_hash_next  = sp_hash;
          w_state_next = S_TX_ACK;
        end
      end

      S_TX_ACK: begin
        if (!tx_busy) begin
          w_tx_data_next  = ACK_BYTE;
          w_tx_start_next = 1'b1;
          w_idx_next      = '0;
          w_ret_next      = S_TX_DIG;
          w_state_next    = S_TX_GAP;
        end
      end

      S_TX_DIG: begin
        if (!tx_busy) begin
          w_tx_data_next  = w_dig_byte;
          w_tx_start_next = 1'b1;
          w_idx_next      = r_idx + 1'b1;
          w_ret_next      = w_dig_last ? S_IDLE : S_TX_DIG;
          w_state_next    = S_TX_GAP;
        end
      end

      S_TX_NAK: begin
        if (!tx_busy) begin
          w_tx_data_next  = NAK_BYTE;
          w_tx_start_next = 1'b1;
          w_ret_next      = S_IDLE;
          w_state_next    = S_TX_GAP;
        end
      end

      // One cycle so the TX core has raised tx_busy before it is tested again.
      S_TX_GAP: begin
        w_state_next = r_ret;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // busy tracks the state it is registered alongside.
    w_busy_next = (w_state_next != S_IDLE);
  end

  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;
  assign sp_start = r_sp_start;
  assign sp_data  = r_sp_data;
  assign sp_valid = r_sp_valid;
  assign sp_last  = r_sp_last;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule

// File: tb/tb_uart_sha256_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_sha256_frame_ctrl
//
// Randomized scoreboard bench. Stimulus tasks push the expected hasher events,
// TX bytes and err-pulse cycles into queues; a monitor pops and compares
// whenever the DUT strobes sp_start / sp_valid / tx_start / err. Small
// behavioural models stand in for the TX core (busy for a few cycles per byte)
// and the hasher (returns the digest chosen by the stimulus).
// -----------------------------------------------------------------------------
module tb_uart_sha256_frame_ctrl;

  localparam int OUT_BYTES = 32;
  localparam int MAX_LEN   = 4096;
  localparam int TO_CYC    = 100;
  localparam int SP_START_TAG = 512;  // scoreboard code for an sp_start event

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_busy = 1'b0;
  logic         sp_start;
  logic [7:0]   sp_data;
  logic         sp_valid;
  logic         sp_last;
  logic [255:0] sp_hash = '0;
  logic         sp_done = 1'b0;
  logic         busy;
  logic         err;

  uart_sha256_frame_ctrl #(
    .LEN_BYTES  (2),
    .MAX_LEN    (MAX_LEN),
    .OUT_BYTES  (OUT_BYTES),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .tx_busy (tx_busy),
    .sp_start(sp_start),
    .sp_data (sp_data),
    .sp_valid(sp_valid),
    .sp_last (sp_last),
    .sp_hash (sp_hash),
    .sp_done (sp_done),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  int           exp_sp[$];    // SP_START_TAG, or {last, data} as last*256+data
  logic [7:0]   exp_tx[$];
  int           exp_err[$];   // cycle number at which err must be seen
  logic [255:0] dig_q[$];     // digests the hasher model will return
  logic [7:0]   payload[$];
  int           tx_seen = 0;
  int           last_rx_edge = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sp_start) begin
          check("sp_start_expected", exp_sp.size() != 0, 1);
          if (exp_sp.size() != 0) check("sp_start_order", exp_sp.pop_front(), SP_START_TAG);
        end
        if (sp_valid) begin
          check("sp_valid_expected", exp_sp.size() != 0, 1);
          if (exp_sp.size() != 0) check("sp_last_data", {sp_last, sp_data}, exp_sp.pop_front());
        end
        if (tx_start) begin
          tx_seen++;
          check("tx_expected", exp_tx.size() != 0, 1);
          if (exp_tx.size() != 0) check("tx_byte", tx_data, exp_tx.pop_front());
        end
        if (err) begin
          check("err_expected", exp_err.size() != 0, 1);
          if (exp_err.size() != 0) check("err_cycle", cyc, exp_err.pop_front());
        end
      end
    end
  end

  // TX core model: busy for a few cycles after each launched byte.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tx_start) begin
        tx_busy = 1'b1;
        repeat ($urandom_range(2, 6)) @(posedge clk);
        #1;
        tx_busy = 1'b0;
      end
    end
  end

  // Hasher model: returns the queued digest a few cycles after the last byte.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sp_valid && sp_last) begin
        repeat ($urandom_range(1, 8)) @(posedge clk);
        #1;
        check("digest_pending", dig_q.size() != 0, 1);
        if (dig_q.size() != 0) sp_hash = dig_q.pop_front();
        sp_done = 1'b1;
        @(posedge clk);
        #1;
        sp_done = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b, input bit nak_here);
    @(posedge clk);
    #1;
    rx_data      = b;
    rx_valid     = 1'b1;
    last_rx_edge = cyc + 1;
    if (nak_here) exp_err.push_back(cyc + 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 4)) @(posedge clk);
  endtask

  // Expected reply for an accepted frame with digest d.
  task automatic push_reply(input logic [255:0] d);
`ifdef UART_SHA_ASCII_HEX_EN
    string s;
    s = $sformatf("%064x", d);
    exp_tx.push_back(8'h06);
    for (int i = 0; i < 2 * OUT_BYTES; i++) exp_tx.push_back(s[i]);
    exp_tx.push_back(8'h0A);
`else
    exp_tx.push_back(8'h06);
    for (int i = 0; i < OUT_BYTES; i++) exp_tx.push_back(d[255 - 8 * i -: 8]);
`endif
    dig_q.push_back(d);
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 4000 && !done; k++) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && exp_sp.size() == 0 && exp_err.size() == 0 && !busy && !tx_busy)
        done = 1'b1;
    end
    check({name, "_complete"}, done, 1);
  endtask

  // Sends SOF, length n and (when legal) the bytes in payload.
  task automatic run_frame(input int n, input logic [255:0] d, input bit junk_after);
    bit ok = (n >= 1) && (n <= MAX_LEN);
    logic [15:0] n16 = 16'(n);
    if (ok) begin
      exp_sp.push_back(SP_START_TAG);
      for (int i = 0; i < n; i++) exp_sp.push_back(((i == n - 1) ? 256 : 0) + int'(payload[i]));
      push_reply(d);
    end else begin
      exp_tx.push_back(8'h15);
    end
    send_byte(8'h01, 1'b0);
    check("busy_after_sof", busy, 1);
    send_byte(n16[15:8], 1'b0);
    send_byte(n16[7:0], !ok);
    if (ok) begin
      for (int i = 0; i < n; i++) send_byte(payload[i], 1'b0);
      // A SOF arriving while hashing/transmitting must be ignored.
      if (junk_after) send_byte(8'h01, 1'b0);
    end
    wait_idle("frame");
    $display("frame len=%0d reply=%s checks=%0d", n, ok ? "ACK" : "NAK", n_checks);
  endtask

  task automatic load_abc();
    payload.delete();
    payload.push_back(8'h61);
    payload.push_back(8'h62);
    payload.push_back(8'h63);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [255:0] d;
    int base;
    bit hit;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {tx_data, tx_start, sp_start, sp_data, sp_valid, sp_last, busy, err}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // "abc" with the real SHA-256 digest
    load_abc();
    run_frame(3, ABC_DIGEST, 1'b1);

    // Binary-transparent payload FF 01
    payload.delete();
    payload.push_back(8'hFF);
    payload.push_back(8'h01);
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_frame(2, d, 1'b0);

    // Zero length, then oversize length, then a good frame
    run_frame(0, '0, 1'b0);
    run_frame(MAX_LEN + 1, '0, 1'b0);
    load_abc();
    run_frame(3, ABC_DIGEST, 1'b0);

    // Boundary length N == MAX_LEN is accepted
    payload.delete();
    for (int i = 0; i < MAX_LEN; i++) payload.push_back(8'($urandom));
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_frame(MAX_LEN, d, 1'b0);

    // Timeout: 01 00 05 61 then silence
    exp_sp.push_back(SP_START_TAG);
    exp_sp.push_back(32'h61);
    exp_tx.push_back(8'h15);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h61, 1'b0);
    exp_err.push_back(last_rx_edge + TO_CYC);
    wait_idle("timeout");
    $display("frame len=5 truncated reply=NAK(timeout) checks=%0d", n_checks);
    load_abc();
    run_frame(3, ABC_DIGEST, 1'b0);

    // Randomized frames, with junk bytes dropped in IDLE
    for (int f = 0; f < 10; f++) begin
      int kind = int'($urandom_range(0, 9));
      int n;
      if (kind == 0)      n = 0;
      else if (kind == 1) n = MAX_LEN + 1 + int'($urandom_range(0, 200));
      else                n = int'($urandom_range(1, 40));
      payload.delete();
      for (int i = 0; i < n && n <= MAX_LEN; i++) begin
        case ($urandom_range(0, 3))
          0:       payload.push_back(8'hFF);
          1:       payload.push_back(8'h01);
          default: payload.push_back(8'($urandom));
        endcase
      end
      if ($urandom_range(0, 1) == 1) send_byte(8'($urandom_range(2, 255)), 1'b0);
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_frame(n, d, ($urandom_range(0, 1) == 1));
    end

    // Reset while the digest is being transmitted
    load_abc();
    exp_sp.push_back(SP_START_TAG);
    exp_sp.push_back(32'h61);
    exp_sp.push_back(32'h62);
    exp_sp.push_back(256 + 32'h63);
    push_reply(ABC_DIGEST);
    base = tx_seen;
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(payload[i], 1'b0);
    hit = 1'b0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(negedge clk);
      if (tx_seen >= base + 11) hit = 1'b1;
    end
    check("reached_digest_byte_10", hit, 1);
    #1;
    rst = 1'b1;
    exp_tx.delete();
    exp_sp.delete();
    @(posedge clk);
    #1;
    check("reset_mid_tx_outputs", {tx_data, tx_start, sp_start, sp_data, sp_valid, sp_last, busy, err}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("reset asserted mid-digest after %0d bytes", tx_seen - base);
    wait_idle("post_reset");
    load_abc();
    run_frame(3, ABC_DIGEST, 1'b0);

    check("sp_queue_empty", exp_sp.size(), 0);
    check("tx_queue_empty", exp_tx.size(), 0);
    check("err_queue_empty", exp_err.size(), 0);
    check("digest_queue_empty", dig_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound so a stuck DUT still terminates.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
